// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/execute controller for the accumulator CPU.
// Owns the program counter and fetches 16-bit words over a req/ack handshake.
// Holds the fetched word for the decoder and emits a one-cycle execute strobe
// per instruction. Supports run, single-step, halt and PC preload.
module instruction_sequencer #(
    parameter int         PC_WIDTH   = 8,
    parameter int         MEM_WAIT   = 1,
    parameter logic [3:0] NOP_OPCODE = 4'h0,
    parameter logic [3:0] LDM_OPCODE = 4'h6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_halt,
    input  logic                i_pc_load,
    input  logic [PC_WIDTH-1:0] i_pc_value,
    output logic [PC_WIDTH-1:0] o_pm_addr,
    output logic                o_pm_req,
    input  logic                i_pm_ack,
    input  logic [15:0]         i_pm_data,
    output logic [15:0]         o_instruction,
    output logic                o_exec_valid,
    output logic                o_busy,
    output logic [15:0]         o_retired
);

    // Word presented to the decoder whenever no instruction is in flight.
    localparam logic [15:0] NOP_WORD = {10'b0, NOP_OPCODE, 2'b00};

    // Wide enough to hold MEM_WAIT, and at least one bit when MEM_WAIT is 0.
    localparam int                CNT_W     = $clog2(MEM_WAIT + 2);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_MEM = 2'd2,
        EXEC     = 2'd3
    } state_t;

    state_t              state_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [15:0]         instr_reg;
    logic                pm_req_reg;
    logic                exec_valid_reg;
    logic                busy_reg;
    logic [15:0]         retired_reg;
    logic                step_flag_reg;
    logic                halt_pending_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;

    // Sequencer FSM; every output is registered and set on the edge that enters its state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg        <= IDLE;
            pc_reg           <= '0;
            instr_reg        <= NOP_WORD;
            pm_req_reg       <= 1'b0;
            exec_valid_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            retired_reg      <= 16'd0;
            step_flag_reg    <= 1'b0;
            halt_pending_reg <= 1'b0;
            wait_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    halt_pending_reg <= 1'b0;
                    instr_reg        <= NOP_WORD;
                    exec_valid_reg   <= 1'b0;
                    pm_req_reg       <= 1'b0;
                    busy_reg         <= 1'b0;
                    if (i_pc_load) begin
                        pc_reg <= i_pc_value;
                    end else if (i_halt) begin
                        state_reg <= IDLE;
                    end else if (i_run) begin
                        state_reg     <= FETCH;
                        step_flag_reg <= 1'b0;
                        pm_req_reg    <= 1'b1;
                        busy_reg      <= 1'b1;
                    end else if (i_step) begin
                        state_reg     <= FETCH;
                        step_flag_reg <= 1'b1;
                        pm_req_reg    <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end

                FETCH: begin
                    if (i_halt) begin
                        halt_pending_reg <= 1'b1;
                    end
                    // The request stays up until acknowledged; nothing but reset aborts it.
                    if (i_pm_ack) begin
                        instr_reg  <= i_pm_data;
                        pc_reg     <= pc_reg + PC_WIDTH'(1);
                        pm_req_reg <= 1'b0;
                        if (MEM_WAIT > 0 && i_pm_data[5:2] == LDM_OPCODE) begin
                            state_reg    <= WAIT_MEM;
                            wait_cnt_reg <= WAIT_INIT;
                        end else begin
                            state_reg      <= EXEC;
                            exec_valid_reg <= 1'b1;
                        end
                    end
                end

                WAIT_MEM: begin
                    if (i_halt) begin
                        halt_pending_reg <= 1'b1;
                    end
                    wait_cnt_reg <= wait_cnt_reg - CNT_ONE;
                    if (wait_cnt_reg == CNT_ONE) begin
                        state_reg      <= EXEC;
                        exec_valid_reg <= 1'b1;
                    end
                end

                EXEC: begin
                    retired_reg    <= retired_reg + 16'd1;
                    exec_valid_reg <= 1'b0;
                    instr_reg      <= NOP_WORD;
                    if (step_flag_reg || halt_pending_reg || i_halt || !i_run) begin
                        state_reg        <= IDLE;
                        busy_reg         <= 1'b0;
                        halt_pending_reg <= 1'b0;
                    end else begin
                        state_reg  <= FETCH;
                        pm_req_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_pm_addr     = pc_reg;
    assign o_pm_req      = pm_req_reg;
    assign o_instruction = instr_reg;
    assign o_exec_valid  = exec_valid_reg;
    assign o_busy        = busy_reg;
    assign o_retired     = retired_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: directed scenarios plus randomized
// programs, checked cycle by cycle against an instruction-level model
// (expected PC, retired count and program memory contents).
module tb_instruction_sequencer;

    localparam int          PC_WIDTH = 8;
    localparam int          MEM_WAIT = 1;
    localparam logic [15:0] NOP_W    = 16'h0000;
    localparam logic [3:0]  LDM_OP   = 4'h6;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                step;
    logic                halt;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_value;
    logic [PC_WIDTH-1:0] pm_addr;
    logic                pm_req;
    logic                pm_ack;
    logic [15:0]         pm_data;
    logic [15:0]         instruction;
    logic                exec_valid;
    logic                busy;
    logic [15:0]         retired;

    int checks   = 0;
    int failures = 0;

    // Model state: program memory, expected PC and retired count.
    logic [15:0]         pmem [256];
    logic [PC_WIDTH-1:0] exp_pc;
    logic [15:0]         exp_retired;

    instruction_sequencer #(
        .PC_WIDTH   (PC_WIDTH),
        .MEM_WAIT   (MEM_WAIT),
        .NOP_OPCODE (4'h0),
        .LDM_OPCODE (LDM_OP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_run         (run),
        .i_step        (step),
        .i_halt        (halt),
        .i_pc_load     (pc_load),
        .i_pc_value    (pc_value),
        .o_pm_addr     (pm_addr),
        .o_pm_req      (pm_req),
        .i_pm_ack      (pm_ack),
        .i_pm_data     (pm_data),
        .o_instruction (instruction),
        .o_exec_valid  (exec_valid),
        .o_busy        (busy),
        .o_retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_req"},     {31'b0, pm_req},     32'd0);
        chk({tag, "_exec"},    {31'b0, exec_valid}, 32'd0);
        chk({tag, "_busy"},    {31'b0, busy},       32'd0);
        chk({tag, "_instr"},   {16'b0, instruction}, {16'b0, NOP_W});
        chk({tag, "_addr"},    {24'b0, pm_addr},    {24'b0, exp_pc});
        chk({tag, "_retired"}, {16'b0, retired},    {16'b0, exp_retired});
    endtask

    // Entered while sampling the first FETCH cycle; returns while sampling EXEC.
    // Noise on pc_load/step while fetching must be ignored by the DUT.
    task automatic fetch_exec(input int delay, input bit halt_first);
        logic [15:0] word;
        bit          is_ldm;
        word   = pmem[exp_pc];
        is_ldm = (word[5:2] == LDM_OP) && (MEM_WAIT > 0);
        for (int c = 0; c <= delay; c++) begin
            chk("fetch_req",   {31'b0, pm_req},      32'd1);
            chk("fetch_addr",  {24'b0, pm_addr},     {24'b0, exp_pc});
            chk("fetch_instr", {16'b0, instruction}, {16'b0, NOP_W});
            chk("fetch_exec",  {31'b0, exec_valid},  32'd0);
            chk("fetch_busy",  {31'b0, busy},        32'd1);
            pm_ack   = (c == delay);
            pm_data  = (c == delay) ? word : 16'($urandom);
            halt     = halt_first && (c == 0);
            pc_load  = (c != delay) ? 1'($urandom_range(0, 1)) : 1'b0;
            step     = (c != delay) ? 1'($urandom_range(0, 1)) : 1'b0;
            pc_value = PC_WIDTH'($urandom);
            tick();
        end
        pm_ack  = 1'b0;
        halt    = 1'b0;
        pc_load = 1'b0;
        step    = 1'b0;
        if (is_ldm) begin
            for (int w = 0; w < MEM_WAIT; w++) begin
                chk("wait_instr", {16'b0, instruction}, {16'b0, word});
                chk("wait_exec",  {31'b0, exec_valid},  32'd0);
                chk("wait_req",   {31'b0, pm_req},      32'd0);
                chk("wait_busy",  {31'b0, busy},        32'd1);
                tick();
            end
        end
        chk("exec_valid",   {31'b0, exec_valid},  32'd1);
        chk("exec_instr",   {16'b0, instruction}, {16'b0, word});
        chk("exec_retired", {16'b0, retired},     {16'b0, exp_retired});
        chk("exec_addr",    {24'b0, pm_addr},     {24'b0, PC_WIDTH'(exp_pc + 1)});
        chk("exec_req",     {31'b0, pm_req},      32'd0);
        exp_pc      = exp_pc + 1'b1;
        exp_retired = exp_retired + 16'd1;
    endtask

    initial begin
        logic [15:0] word;
        int          n;
        bit          use_halt;

        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
        pc_load = 1'b0; pc_value = '0; pm_ack = 1'b0; pm_data = 16'h0;
        for (int i = 0; i < 256; i++) pmem[i] = 16'h0;
        exp_pc = '0; exp_retired = 16'd0;

        // Reset state.
        tick(); tick();
        idle_chk("reset");
        rst = 1'b0;
        tick();
        idle_chk("post_reset");

        // Continuous run with zero-wait ack over three words.
        pmem[0] = 16'h0004; pmem[1] = 16'h0008; pmem[2] = 16'h000C;
        run = 1'b1;
        tick();
        fetch_exec(0, 0); tick();
        fetch_exec(0, 0); tick();
        fetch_exec(0, 0);
        run = 1'b0;
        tick();
        idle_chk("run3");
        chk("run3_retired3", {16'b0, retired}, 32'd3);

        // Single step with ack delayed three cycles; run held high in EXEC to
        // prove the step flag alone returns to IDLE.
        pmem[3] = 16'h1234;
        step = 1'b1; tick(); step = 1'b0;
        fetch_exec(3, 0);
        run = 1'b1; tick(); run = 1'b0;
        idle_chk("ackdelay");

        // LDM with wait state.
        pmem[4] = {10'h3FF, LDM_OP, 2'b00};
        step = 1'b1; tick(); step = 1'b0;
        fetch_exec(0, 0);
        tick();
        idle_chk("ldm");

        // pc_load beats run; halt beats run in IDLE.
        pc_load = 1'b1; pc_value = 8'h5A; run = 1'b1;
        tick();
        pc_load = 1'b0; run = 1'b0; exp_pc = 8'h5A;
        idle_chk("pcload_prio");
        halt = 1'b1; run = 1'b1;
        tick();
        halt = 1'b0; run = 1'b0;
        idle_chk("halt_prio");

        // Reset, preload FE and step three times across the wrap.
        rst = 1'b1; tick(); rst = 1'b0;
        exp_pc = '0; exp_retired = 16'd0;
        idle_chk("reset2");
        pc_load = 1'b1; pc_value = 8'hFE; tick(); pc_load = 1'b0;
        exp_pc = 8'hFE;
        idle_chk("preload_fe");
        pmem[8'hFE] = 16'h0101; pmem[8'hFF] = 16'h0018; pmem[8'h00] = 16'h8024;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; tick(); step = 1'b0;
            fetch_exec(int'($urandom_range(0, 2)), 0);
            tick();
            idle_chk("step_wrap");
        end
        chk("step_wrap_retired3", {16'b0, retired}, 32'd3);
        chk("step_wrap_pc",       {24'b0, pm_addr}, 32'd1);

        // Halt pulsed mid-FETCH with run held: one execution, IDLE, then restart at PC+1.
        pmem[1] = 16'h0044; pmem[2] = 16'h0048;
        run = 1'b1;
        tick();
        fetch_exec(2, 1);
        tick();
        idle_chk("halt_fetch");
        tick();
        fetch_exec(0, 0);
        halt = 1'b1;
        tick();
        halt = 1'b0; run = 1'b0;
        idle_chk("halt_exec");

        // Randomized programs from random start addresses.
        for (int r = 0; r < 16; r++) begin
            pc_load = 1'b1; pc_value = PC_WIDTH'($urandom); tick(); pc_load = 1'b0;
            exp_pc = pc_value;
            idle_chk("rand_load");
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                word = 16'($urandom);
                if ($urandom_range(0, 2) == 0) word[5:2] = LDM_OP;
                pmem[PC_WIDTH'(exp_pc + PC_WIDTH'(k))] = word;
            end
            if (n == 1) begin
                step = 1'b1; tick(); step = 1'b0;
                fetch_exec(int'($urandom_range(0, 3)), 0);
                run = 1'b1; tick(); run = 1'b0;
            end else begin
                run = 1'b1; tick();
                for (int k = 0; k < n; k++) begin
                    fetch_exec(int'($urandom_range(0, 3)), 0);
                    if (k == n - 1) begin
                        use_halt = 1'($urandom_range(0, 1));
                        if (use_halt) halt = 1'b1;
                        else run = 1'b0;
                    end
                    tick();
                end
                halt = 1'b0; run = 1'b0;
            end
            idle_chk("rand_end");
        end

        // Reset asserted in WAIT_MEM; a stale ack afterwards must be ignored.
        pmem[exp_pc] = 16'h0018;
        step = 1'b1; tick(); step = 1'b0;
        chk("rstwait_req", {31'b0, pm_req}, 32'd1);
        pm_ack = 1'b1; pm_data = pmem[exp_pc];
        tick();
        chk("rstwait_instr", {16'b0, instruction}, 32'h0018);
        chk("rstwait_exec",  {31'b0, exec_valid},  32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = '0; exp_retired = 16'd0;
        idle_chk("rst_in_wait");
        tick();
        idle_chk("stale_ack");
        pm_ack = 1'b0;
        tick();
        idle_chk("after_stale");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/execute controller for the accumulator CPU. It owns the program counter, fetches 16-bit instruction words from program memory over a req/ack handshake, and holds each word in an instruction register. That register drives the instruction decoder (`i_instruction`). It also produces an execute strobe that the top level uses to gate the decoder's state-changing enables, and it supports continuous run, single-step, halt and PC preload.

## Interface
- `PC_WIDTH`, 8: program counter / program memory address width.
- `MEM_WAIT`, 1: extra cycles inserted before executing an LDM, covering data memory read latency; 0 allowed.
- `NOP_OPCODE`, 4'h0: operation field value of NOP, placed in instruction bits [5:2].
- `LDM_OPCODE`, 4'h6: operation field value of LDM.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_run`  in  1  level; run continuously while high.
- `i_step`  in  1  pulse; execute exactly one instruction from IDLE.
- `i_halt`  in  1  pulse; stop after the current instruction completes.
- `i_pc_load`  in  1  load PC from `i_pc_value` (honoured in IDLE only).
- `i_pc_value`  in  PC_WIDTH  preload value.
- `o_pm_addr`  out  PC_WIDTH  program memory address (= PC).
- `o_pm_req`  out  1  fetch request.
- `i_pm_ack`  in  1  fetch acknowledge; `i_pm_data` valid in the same cycle.
- `i_pm_data`  in  16  fetched instruction word.
- `o_instruction`  out  16  to decoder.
- `o_exec_valid`  out  1  high for exactly one cycle per instruction. Top level ANDs it into the accumulator CE, RF CE (active-low, so it is forced high when this strobe is low) and memory write enable. Memory read enable is not gated.
- `o_busy`  out  1  high in any state except IDLE.
- `o_retired`  out  16  count of executed instructions; wraps modulo 2^16.

## Operation
- States: IDLE, FETCH, WAIT_MEM, EXEC.
- Reset values:
  - state IDLE, PC 0.
  - `o_instruction` = {10'b0, NOP_OPCODE, 2'b0}.
  - `o_pm_req` 0, `o_exec_valid` 0, `o_busy` 0, `o_retired` 0.
  - step flag 0, halt_pending 0.
- IDLE:
  - `o_instruction` = NOP word.
  - Priority: `i_pc_load` (PC <= `i_pc_value`, stay IDLE) > `i_halt` (stay IDLE) > `i_run` (-> FETCH, step flag 0) > `i_step` (-> FETCH, step flag 1).
  - halt_pending is cleared in IDLE.
- FETCH:
  - `o_pm_req`=1, `o_pm_addr`=PC. Request is held until `i_pm_ack`.
  - On ack:
    - IR <= `i_pm_data`.
    - PC <= PC+1, wrapping from 2^PC_WIDTH-1 to 0.
    - If IR[5:2]==LDM_OPCODE and MEM_WAIT>0: -> WAIT_MEM, counter <= MEM_WAIT. Otherwise -> EXEC.
  - A fetch, once requested, is never aborted except by reset.
- WAIT_MEM:
  - `o_instruction`=IR, `o_exec_valid`=0.
  - Counter decrements each cycle; -> EXEC on the cycle it reaches 1.
- EXEC:
  - `o_instruction`=IR, `o_exec_valid`=1, `o_retired` += 1.
  - Next state: if step flag, halt_pending, or `i_halt` this cycle, or `i_run`=0 -> IDLE. Otherwise -> FETCH.
- `i_halt` in FETCH/WAIT_MEM/EXEC sets halt_pending. It takes effect at the end of EXEC.
- `i_pc_load` and `i_step` outside IDLE are ignored.
- `o_instruction` in FETCH = NOP word, so no decoder enables fire while fetching.
- Reset mid-operation: return to the reset values on the next edge. An outstanding `i_pm_ack` after reset is ignored, because `o_pm_req`=0.

## Timing
- Zero-wait ack (ack in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- LDM: 2+MEM_WAIT cycles.
- Each cycle of ack delay adds one FETCH cycle.
- IR and PC update on the edge ending the ack cycle. `o_exec_valid` rises the following cycle, at the earliest.
- `o_pm_addr` is registered PC: stable throughout FETCH and updated only after the ack edge.
- `o_retired` increments on the edge ending EXEC. `o_busy` drops on the edge EXEC->IDLE.

## Test plan
- Reset, then `i_run`=1 with zero-wait ack, memory words 0x0004/0x0008/0x000C: `o_pm_addr` 0,1,2 on alternate cycles; `o_exec_valid` pulses every 2nd cycle; `o_retired`=3 after 6 cycles of run.
- Ack delayed 3 cycles: `o_pm_req` held 4 cycles with `o_pm_addr` constant; exactly one `o_exec_valid` pulse; PC +1.
- LDM word {10'h3FF, LDM_OPCODE, 2'b00}, MEM_WAIT=1: `o_instruction`=that word for 2 cycles, `o_exec_valid` high only in the 2nd.
- IDLE, pc_load 8'hFE, `i_step` three times: addresses FE, FF, 00; returns to IDLE after each step; `o_retired`=3.
- `i_halt` pulsed mid-FETCH during run with `i_run` high: current instruction executes once, then IDLE with `o_busy`=0; holding `i_run` then restarts at PC+1.
- `i_rst` asserted in WAIT_MEM: next cycle PC=0, NOP word on `o_instruction`, `o_exec_valid`=0, `o_retired`=0.
